// File: rtl/reg_wb_queue.sv
// In-order write-back queue feeding the register file write port,
// with pending-write lookup and youngest-entry forwarding for two read ports.
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rw,
    input  logic [31:0]   in_data,
    input  logic          wr_hold,
    output logic          RegWr,
    output logic [4:0]    Rw,
    output logic [31:0]   busW,
    input  logic [4:0]    Ra,
    input  logic [4:0]    Rb,
    output logic          hitA,
    output logic          hitB,
    output logic [31:0]   fwdA,
    output logic [31:0]   fwdB,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);

    logic [4:0]    q_rw   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign in_ready = !full;

    // Requests to r0 are accepted and dropped.
    assign push = in_valid && in_ready && (in_rw != 5'd0);
    assign pop  = RegWr;

    assign RegWr = !empty && !wr_hold;
    assign Rw    = empty ? 5'd0 : q_rw[rd_ptr];
    assign busW  = empty ? 32'd0 : q_data[rd_ptr];

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        hitA = 1'b0;
        hitB = 1'b0;
        fwdA = 32'd0;
        fwdB = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                if (Ra != 5'd0 && q_rw[rd_ptr + PW'(i)] == Ra) begin
                    hitA = 1'b1;
                    fwdA = q_data[rd_ptr + PW'(i)];
                end
                if (Rb != 5'd0 && q_rw[rd_ptr + PW'(i)] == Rb) begin
                    hitB = 1'b1;
                    fwdB = q_data[rd_ptr + PW'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_rw[i]   <= 5'd0;
                q_data[i] <= 32'd0;
            end
        end else begin
            if (push) begin
                q_rw[wr_ptr]   <= in_rw;
                q_data[wr_ptr] <= in_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
